// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and receiver blocks:
//   - parity mode encoding (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - frame FSM state encoding
//   - parity_bit(): parity helper for a frame's data bits
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } uart_state_e;

    // Data narrower than 8 bits must arrive zero-extended, so the XOR
    // still covers only the real data bits.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic even_s;
        even_s = ^data;
        case (mode)
            PAR_ODD:  parity_bit = ~even_s;
            PAR_EVEN: parity_bit = even_s;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered status flags.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   wr_en    in   push wr_data; dropped when full unless a pop happens in the same cycle
//   wr_data  in   WIDTH-bit word to store
//   rd_en    in   pop the head word; ignored when empty
//   rd_data  out  head word (valid while empty=0)
//   full     out  DEPTH words held
//   empty    out  no words held
//   count    out  occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Qualify push/pop and compute the next occupancy.
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    always_comb begin
        rd_ok_s     = rd_en & ~empty_r;
        wr_ok_s     = wr_en & (~full_r | rd_ok_s);
        count_nxt_s = count_r;
        if (wr_ok_s && !rd_ok_s) begin
            count_nxt_s = count_r + (AW+1)'(1'b1);
        end else if (!wr_ok_s && rd_ok_s) begin
            count_nxt_s = count_r - (AW+1)'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage write port; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ok_s ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
            rd_ptr_r <= rd_ok_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == (AW+1)'(DEPTH));
            empty_r  <= (count_nxt_s == {(AW+1){1'b0}});
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_pkt.sv
// uart_tx_pkt
// Buffered UART transmitter: bytes are queued in a FIFO and sent as
// start / data (LSB first) / optional parity / stop bits, then an optional
// idle gap. Frames from a non-empty FIFO follow each other with no idle cycle.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset; aborts any frame, flushes FIFO
//   wr_en     in   queue wr_data this cycle
//   wr_data   in   DATA_BITS-wide word to send
//   tx        out  serial line, idle high (registered)
//   busy      out  frame or gap in progress (registered)
//   full      out  FIFO holds DEPTH entries (registered)
//   empty     out  FIFO holds no entries (registered)
//   count     out  FIFO occupancy (registered)
//   overflow  out  one-cycle pulse after a write was dropped (registered)
module uart_tx_pkt #(
    parameter int BAUD_END  = 433,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 8,
    parameter int GAP_BITS  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_BITS-1:0]     wr_data,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    import uart_pkg::*;

    localparam int BAUD_W = (BAUD_END > 0) ? $clog2(BAUD_END + 1) : 1;
    localparam int BIT_W  = 16;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_END);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY);

    uart_state_e            state_r, state_nxt_s;
    logic [BAUD_W-1:0]      baud_r, baud_nxt_s;
    logic [BIT_W-1:0]       bit_r, bit_nxt_s;
    logic [DATA_BITS-1:0]   shift_r, shift_nxt_s;
    logic                   par_r, par_nxt_s;
    logic                   tx_r, tx_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   overflow_r, overflow_nxt_s;
    logic                   bit_end_s;
    logic                   slot_free_s;
    logic                   pop_s;

    logic [DATA_BITS-1:0]   fifo_dout_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (fifo_dout_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign bit_end_s = (baud_r == BAUD_LAST);

    // Next-state logic. tx_nxt_s is the value the line takes in the next
    // state, so tx changes on the same edge as the state register.
    // slot_free_s marks the point where a new frame may begin (idle, or end
    // of the last stop/gap bit); the FIFO head is popped right there.
    always_comb begin
        state_nxt_s    = state_r;
        baud_nxt_s     = baud_r + BAUD_W'(1'b1);
        bit_nxt_s      = bit_r;
        shift_nxt_s    = shift_r;
        par_nxt_s      = par_r;
        tx_nxt_s       = tx_r;
        slot_free_s    = 1'b0;
        pop_s          = 1'b0;

        case (state_r)
            ST_IDLE: begin
                baud_nxt_s  = {BAUD_W{1'b0}};
                slot_free_s = 1'b1;
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                    baud_nxt_s  = {BAUD_W{1'b0}};
                    bit_nxt_s   = {BIT_W{1'b0}};
                    tx_nxt_s    = shift_r[0];
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_nxt_s = {BAUD_W{1'b0}};
                    if (bit_r == DATA_LAST) begin
                        bit_nxt_s = {BIT_W{1'b0}};
                        if (PAR_MODE != PAR_NONE) begin
                            state_nxt_s = ST_PARITY;
                            tx_nxt_s    = par_r;
                        end else begin
                            state_nxt_s = ST_STOP;
                            tx_nxt_s    = 1'b1;
                        end
                    end else begin
                        bit_nxt_s   = bit_r + BIT_W'(1'b1);
                        shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
                        tx_nxt_s    = shift_r[1];
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                    baud_nxt_s  = {BAUD_W{1'b0}};
                    bit_nxt_s   = {BIT_W{1'b0}};
                    tx_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_nxt_s = {BAUD_W{1'b0}};
                    if (bit_r == STOP_LAST) begin
                        bit_nxt_s = {BIT_W{1'b0}};
                        if (GAP_BITS > 0) begin
                            state_nxt_s = ST_GAP;
                            tx_nxt_s    = 1'b1;
                        end else begin
                            slot_free_s = 1'b1;
                        end
                    end else begin
                        bit_nxt_s = bit_r + BIT_W'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_GAP: begin
                if (bit_end_s) begin
                    baud_nxt_s = {BAUD_W{1'b0}};
                    if (bit_r == GAP_LAST) begin
                        bit_nxt_s   = {BIT_W{1'b0}};
                        slot_free_s = 1'b1;
                    end else begin
                        bit_nxt_s = bit_r + BIT_W'(1'b1);
                    end
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                baud_nxt_s  = {BAUD_W{1'b0}};
                bit_nxt_s   = {BIT_W{1'b0}};
                tx_nxt_s    = 1'b1;
            end
        endcase

        if (slot_free_s) begin
            baud_nxt_s = {BAUD_W{1'b0}};
            bit_nxt_s  = {BIT_W{1'b0}};
            if (!fifo_empty_s) begin
                pop_s       = 1'b1;
                state_nxt_s = ST_START;
                shift_nxt_s = fifo_dout_s;
                par_nxt_s   = parity_bit(8'(fifo_dout_s), PAR_MODE);
                tx_nxt_s    = 1'b0;
            end else begin
                state_nxt_s = ST_IDLE;
                tx_nxt_s    = 1'b1;
            end
        end else begin
            pop_s = 1'b0;
        end

        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        overflow_nxt_s = wr_en & fifo_full_s & ~pop_s;
    end

    // Frame state and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_r     <= {BAUD_W{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            baud_r     <= baud_nxt_s;
            bit_r      <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            par_r      <= par_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= busy_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign full     = fifo_full_s;
    assign empty    = fifo_empty_s;
    assign count    = fifo_count_s;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_pkt.sv
// Testbench for uart_tx_pkt. Three instances with BAUD_END=28:
//   u[0]: 8N1, no gap     u[1]: 8E2     u[2]: 8N1 with 3 gap bits
// Writes push expected bytes into a per-instance queue; a per-instance
// line monitor decodes frames from tx and compares against the queue.
module tb_uart_tx_pkt;

    localparam int BIT_CYC = 29;

    logic       clk;
    logic       rst;
    logic [2:0] wr_en_a;
    logic [7:0] wr_data_a [3];
    logic [2:0] tx_a;
    logic [2:0] busy_a;
    logic [2:0] full_a;
    logic [2:0] empty_a;
    logic [2:0] overflow_a;
    logic [3:0] count_a [3];

    logic [7:0] exp_q [3][$];
    bit         chk_gap [3];
    int         total = 0;
    int         bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int PAR_G  = (g == 1) ? 2 : 0;
        localparam int STOP_G = (g == 1) ? 2 : 1;
        localparam int GAP_G  = (g == 2) ? 3 : 0;

        uart_tx_pkt #(
            .BAUD_END  (28),
            .DATA_BITS (8),
            .PARITY    (PAR_G),
            .STOP_BITS (STOP_G),
            .DEPTH     (8),
            .GAP_BITS  (GAP_G)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en_a[g]),
            .wr_data  (wr_data_a[g]),
            .tx       (tx_a[g]),
            .busy     (busy_a[g]),
            .full     (full_a[g]),
            .empty    (empty_a[g]),
            .count    (count_a[g]),
            .overflow (overflow_a[g])
        );

        logic ab;

        // Called on the first cycle of a bit; requires the level to hold for
        // BIT_CYC cycles and returns positioned on the first cycle of the next bit.
        task automatic take_bit(output logic v, output bit ok);
            v  = tx_a[g];
            ok = 1'b1;
            if (rst) ab = 1'b1;
            repeat (BIT_CYC - 1) begin
                @(negedge clk);
                if (rst) ab = 1'b1;
                if (tx_a[g] !== v) ok = 1'b0;
            end
            @(negedge clk);
        endtask

        initial begin : mon
            logic [7:0] d;
            logic [7:0] e;
            logic       b;
            logic       p;
            logic       ep;
            bit         ok;
            bit         good;
            int         idle_run;
            idle_run = -1;
            @(negedge clk);
            forever begin
                if (!rst && tx_a[g] === 1'b0) begin
                    if (chk_gap[g] && idle_run >= 0)
                        check($sformatf("gap_u%0d", g), idle_run, GAP_G * BIT_CYC);
                    ab   = 1'b0;
                    good = 1'b1;
                    take_bit(b, ok);
                    good = good & ok & (b === 1'b0);
                    for (int i = 0; i < 8; i++) begin
                        take_bit(b, ok);
                        good = good & ok;
                        d[i] = b;
                    end
                    if (PAR_G != 0) begin
                        take_bit(p, ok);
                        good = good & ok;
                    end else begin
                        p = 1'b0;
                    end
                    for (int s = 0; s < STOP_G; s++) begin
                        take_bit(b, ok);
                        good = good & ok & (b === 1'b1);
                    end
                    idle_run = 0;
                    if (ab) begin
                        idle_run = -1;
                    end else if (exp_q[g].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame_u%0d: got %02h want none", g, d);
                    end else begin
                        e  = exp_q[g].pop_front();
                        ep = (PAR_G == 1) ? ~^e : ((PAR_G == 2) ? ^e : 1'b0);
                        // {timing/level ok, parity bit, data}
                        check($sformatf("frame_u%0d", g), {22'd0, good, p, d}, {22'd0, 1'b1, ep, e});
                    end
                end else begin
                    if (!chk_gap[g] || rst) idle_run = -1;
                    else if (idle_run >= 0) idle_run++;
                    @(negedge clk);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int g, input logic [7:0] d, input bit accepted);
        wr_en_a[g]   = 1'b1;
        wr_data_a[g] = d;
        if (accepted) exp_q[g].push_back(d);
        tick();
        wr_en_a[g] = 1'b0;
    endtask

    task automatic drain(input int g, input int limit);
        int n;
        n = 0;
        while ((exp_q[g].size() != 0 || busy_a[g]) && n < limit) begin
            tick();
            n++;
        end
        chk1($sformatf("drain_u%0d", g), (n < limit), 1'b1);
    endtask

    initial begin : stim
        int n;
        rst     = 1'b1;
        wr_en_a = 3'b000;
        for (int g = 0; g < 3; g++) begin
            wr_data_a[g] = 8'h00;
            chk_gap[g]   = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;

        // reset state
        chk1("rst_tx", tx_a[0], 1'b1);
        chk1("rst_busy", busy_a[0], 1'b0);
        chk1("rst_full", full_a[0], 1'b0);
        chk1("rst_empty", empty_a[0], 1'b1);
        check("rst_count", 32'(count_a[0]), 32'd0);
        chk1("rst_ovf", overflow_a[0], 1'b0);
        tick();

        // single 0x55 frame: latency and length
        write(0, 8'h55, 1'b1);
        chk1("lat_tx_hold", tx_a[0], 1'b1);
        check("lat_count", 32'(count_a[0]), 32'd1);
        tick();
        chk1("lat_tx_low", tx_a[0], 1'b0);
        chk1("lat_busy", busy_a[0], 1'b1);
        chk1("lat_empty", empty_a[0], 1'b1);
        n = 0;
        while (busy_a[0] && n < 1000) begin
            tick();
            n++;
        end
        check("len_8n1", n, 32'd290);
        chk1("len_8n1_tx", tx_a[0], 1'b1);
        drain(0, 200);

        // 8E2: 0x07 has parity bit 1, frame 12 bits long
        write(1, 8'h07, 1'b1);
        tick();
        n = 0;
        while (busy_a[1] && n < 1000) begin
            tick();
            n++;
        end
        check("len_8e2", n, 32'd348);
        drain(1, 200);

        // overflow: 10 consecutive writes, first popped at once, 10th dropped
        for (int i = 0; i < 10; i++) begin
            write(0, 8'(8'hA0 + i), (i < 9));
            if (i == 8) begin
                check("fill_count", 32'(count_a[0]), 32'd8);
                chk1("fill_full", full_a[0], 1'b1);
                chk1("fill_no_ovf", overflow_a[0], 1'b0);
            end
        end
        chk1("ovf_pulse", overflow_a[0], 1'b1);
        check("ovf_count", 32'(count_a[0]), 32'd8);
        tick();
        chk1("ovf_clear", overflow_a[0], 1'b0);
        // write while full on the very edge that pops the next frame
        repeat (280) tick();
        check("fullpop_pre_count", 32'(count_a[0]), 32'd8);
        chk1("fullpop_pre_tx", tx_a[0], 1'b1);
        write(0, 8'hB0, 1'b1);
        check("fullpop_count", 32'(count_a[0]), 32'd8);
        chk1("fullpop_no_ovf", overflow_a[0], 1'b0);
        chk1("fullpop_tx_start", tx_a[0], 1'b0);
        drain(0, 4000);

        // six back-to-back frames, no idle between them
        chk_gap[0] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) write(0, 8'(8'h11 * (i + 1)), 1'b1);
        drain(0, 3000);
        chk_gap[0] = 1'b0;

        // three gap bits between two frames
        chk_gap[2] = 1'b1;
        tick();
        tick();
        write(2, 8'hC3, 1'b1);
        write(2, 8'h3C, 1'b1);
        drain(2, 1500);
        chk_gap[2] = 1'b0;

        // reset mid-DATA of a 3-byte burst, with a write during reset
        write(0, 8'h31, 1'b1);
        write(0, 8'h32, 1'b1);
        write(0, 8'h33, 1'b1);
        repeat (100) tick();
        chk1("mid_busy", busy_a[0], 1'b1);
        rst          = 1'b1;
        wr_en_a[0]   = 1'b1;
        wr_data_a[0] = 8'h99;
        exp_q[0].delete();
        tick();
        rst        = 1'b0;
        wr_en_a[0] = 1'b0;
        chk1("abort_tx", tx_a[0], 1'b1);
        chk1("abort_busy", busy_a[0], 1'b0);
        chk1("abort_empty", empty_a[0], 1'b1);
        check("abort_count", 32'(count_a[0]), 32'd0);
        repeat (1000) tick();
        chk1("after_tx", tx_a[0], 1'b1);
        chk1("after_busy", busy_a[0], 1'b0);
        check("after_count", 32'(count_a[0]), 32'd0);

        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
